// File: rtl/uart_transceiver.sv
// 8N1 UART transmitter and receiver sharing one clock domain.
// The RX input is brought in through a two-flop synchroniser before any decision is made on it.
`timescale 1ns/1ps
module uart_transceiver #(
  parameter int CLK_FREQ     = 24_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_we,
  input  logic [7:0] wr_data,
  output logic       uart_tx,
  output logic       tx_busy,
  input  logic       uart_rx,
  output logic       uart_re,
  output logic [7:0] rd_data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_busy_q, tx_busy_d;

  logic             rx_meta_q, rx_sync_q;
  state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             re_q, re_d;

  // The line level is registered from the next state so uart_tx is glitch-free.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      S_IDLE: if (uart_we) begin
        tx_state_d = S_START;
        tx_shift_d = wr_data;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_line_d  = 1'b0;
        tx_busy_d  = 1'b1;
      end
      S_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = S_DATA;
        tx_line_d  = tx_shift_q[0];
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      S_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP;
          tx_line_d  = 1'b1;
        end else tx_line_d = tx_shift_q[1];
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      S_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = S_IDLE;
        tx_busy_d  = 1'b0;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = S_IDLE;
    endcase
  end

  // START samples at mid-bit; DATA/STOP then sample a full bit period apart.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rd_data_d  = rd_data_q;
    re_d       = 1'b0;
    case (rx_state_q)
      S_IDLE: if (!rx_sync_q) begin
        rx_state_d = S_START;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
      end
      S_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      S_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      S_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
        if (rx_sync_q) begin
          rd_data_d = rx_shift_q;
          re_d      = 1'b1;
        end
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rd_data_q  <= '0;
      re_q       <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rd_data_q  <= rd_data_d;
      re_q       <= re_d;
    end
  end

  assign uart_tx = tx_line_q;
  assign tx_busy = tx_busy_q;
  assign uart_re = re_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: loopback and bench-driven RX frames,
// with received bytes checked against a queue of expected bytes.
`timescale 1ns/1ps
module tb_uart_transceiver;
  localparam int CPB = 208;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_we = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       uart_tx, tx_busy, uart_re;
  logic [7:0] rd_data;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b1;
  logic       uart_rx;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         busy_run = 0;
  int         busy_len = 0;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  uart_transceiver #(
    .CLK_FREQ (24_000_000),
    .BAUD_RATE(115200)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .uart_we(uart_we),
    .wr_data(wr_data),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy),
    .uart_rx(uart_rx),
    .uart_re(uart_re),
    .rd_data(rd_data)
  );

  always #20.833 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding expected byte.
  always @(negedge clk) begin
    if (rst_n && uart_re) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rx_unexpected: observed strobe with rd_data %0h expected no strobe", rd_data);
      end
      if (exp_q.size() != 0) check("rx_byte", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  // Length of the most recent completed tx_busy pulse, in cycles.
  always @(negedge clk) begin
    if (!rst_n) busy_run <= 0;
    else if (tx_busy) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      busy_len <= busy_run;
      busy_run <= 0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    uart_we = 1'b1;
    wr_data = b;
    @(negedge clk);
    uart_we = 1'b0;
    wr_data = $urandom_range(0, 255);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(tx_busy), 32'd0);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      wait_cycles(CPB);
    end
    rx_drv = stop;
    wait_cycles(stop ? CPB : (CPB * 5) / 8);
    rx_drv = 1'b1;
    wait_cycles(2 * CPB);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"},   32'(uart_tx), 32'd1);
    check({tag, "_busy"}, 32'(tx_busy), 32'd0);
    check({tag, "_re"},   32'(uart_re), 32'd0);
    check({tag, "_rd"},   32'(rd_data), 32'h00);
  endtask

  initial begin
    logic [9:0] frame;

    wait_cycles(3);
    check_reset_outputs("por");
    rst_n = 1'b1;
    wait_cycles(10);

    // Loopback 0x43 with the serial waveform checked at each bit centre.
    frame = {1'b1, 8'h43, 1'b0};
    exp_q.push_back(8'h43);
    send(8'h43);
    wait_cycles(CPB / 2 - 1);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx43_bit%0d", k), 32'(uart_tx), 32'(frame[k]));
      if (k < 9) wait_cycles(CPB);
    end
    wait_idle("tx43_idle");
    wait_cycles(320);
    check("rx43_done", 32'(exp_q.size()), 32'd0);

    exp_q.push_back(8'h50);
    send(8'h50);
    wait_idle("tx50_idle");
    wait_cycles(1);
    check("tx50_busy_len", 32'(busy_len), 32'd2080);
    check("rx50_done", 32'(exp_q.size()), 32'd0);
    wait_cycles(318);

    exp_q.push_back(8'h55);
    send(8'h55);
    wait_idle("tx55_idle");
    wait_cycles(1);
    check("tx55_busy_len", 32'(busy_len), 32'd2080);
    check("rx55_done", 32'(exp_q.size()), 32'd0);
    wait_cycles(318);

    // Write while busy is ignored.
    exp_q.push_back(8'hAA);
    send(8'hAA);
    wait_cycles(498);
    send(8'h0F);
    wait_idle("txAA_idle");
    wait_cycles(1);
    check("txAA_busy_len", 32'(busy_len), 32'd2080);
    wait_cycles(2200);
    check("txAA_no_second", 32'(tx_busy), 32'd0);
    check("rxAA_done", 32'(exp_q.size()), 32'd0);
    check("rxAA_data", 32'(rd_data), 32'hAA);

    // Start glitch shorter than half a bit.
    loop_en = 1'b0;
    wait_cycles(10);
    rx_drv = 1'b0;
    wait_cycles(50);
    rx_drv = 1'b1;
    wait_cycles(400);
    check("glitch_rd_hold", 32'(rd_data), 32'hAA);

    // Framing error, then a good frame.
    drive_frame(8'h3C, 1'b0);
    check("frame_err_rd_hold", 32'(rd_data), 32'hAA);
    exp_q.push_back(8'h81);
    drive_frame(8'h81, 1'b1);
    check("rx81_done", 32'(exp_q.size()), 32'd0);
    check("rx81_data", 32'(rd_data), 32'h81);

    // Back-to-back frames with the second write in the first idle cycle.
    loop_en = 1'b1;
    wait_cycles(10);
    exp_q.push_back(8'h00);
    send(8'h00);
    wait_idle("tx00_idle");
    exp_q.push_back(8'hFF);
    send(8'hFF);
    check("txFF_accepted", 32'(tx_busy), 32'd1);
    check("tx00_busy_len", 32'(busy_len), 32'd2080);
    wait_idle("txFF_idle");
    wait_cycles(1);
    check("txFF_busy_len", 32'(busy_len), 32'd2080);
    wait_cycles(300);
    check("rxFF_done", 32'(exp_q.size()), 32'd0);
    check("rxFF_data", 32'(rd_data), 32'hFF);

    // Asynchronous reset in the middle of a frame.
    send(8'h3C);
    wait_cycles(1000);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2500);
    check("postrst_rd", 32'(rd_data), 32'h00);
    check("postrst_tx", 32'(uart_tx), 32'd1);
    check("postrst_busy", 32'(tx_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
